// File: rtl/vga_pkg.sv
// Shared 640x480@60 VGA timing constants and the pixel coordinate type.
// Used by vga_timing_gen and by downstream consumers such as graphics_driver.
package vga_pkg;

   localparam int unsigned COUNT_W  = 10;

   localparam int unsigned H_ACTIVE = 640;
   localparam int unsigned H_FP     = 16;
   localparam int unsigned H_SYNC   = 96;
   localparam int unsigned H_BP     = 48;
   localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

   localparam int unsigned V_ACTIVE = 480;
   localparam int unsigned V_FP     = 10;
   localparam int unsigned V_SYNC   = 2;
   localparam int unsigned V_BP     = 33;
   localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

   typedef logic [COUNT_W-1:0] coord_t;

endpackage

// File: rtl/vga_pix_divider.sv
// Pixel-enable divider: div counter runs 0..CLK_DIV-1 and a registered tick is
// high for one clk every CLK_DIV clks. tick_next_o is the value pix_tick_o takes
// at the next edge, so pixel-clocked state can update in the same clk as the tick.
module vga_pix_divider #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   output logic tick_next_o,
   output logic pix_tick_o
);

   localparam int unsigned     DivW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

   logic [DivW-1:0] div_q, div_d;
   logic            tick_q;

   // Next divider count with wrap; the tick fires while the count sits at its last value.
   always_comb begin
      div_d       = div_q + DivW'(1);
      tick_next_o = (div_q == DivLast);
      if (div_q == DivLast) begin
         div_d = '0;
      end
   end

   // Divider and tick registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         div_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         div_q  <= div_d;
         tick_q <= tick_next_o;
      end
   end

   assign pix_tick_o = tick_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel counters, syncs, blanking and line/frame strobes.
// All outputs are registered and decoded from next-state counts, so they change in
// the same clk as hc/vc. Optional VGA_FRAME_COUNT_EN adds a 16-bit frame counter.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int unsigned CLK_DIV  = 4,
   parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
   parameter int unsigned H_FP     = vga_pkg::H_FP,
   parameter int unsigned H_SYNC   = vga_pkg::H_SYNC,
   parameter int unsigned H_BP     = vga_pkg::H_BP,
   parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
   parameter int unsigned V_FP     = vga_pkg::V_FP,
   parameter int unsigned V_SYNC   = vga_pkg::V_SYNC,
   parameter int unsigned V_BP     = vga_pkg::V_BP
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   output logic        pix_tick_o,
   output coord_t      hc_o,
   output coord_t      vc_o,
   output logic        hsync_o,
   output logic        vsync_o,
   output logic        video_on_o,
   output logic        line_start_o,
   output logic        frame_start_o
`ifdef VGA_FRAME_COUNT_EN
   ,
   output logic [15:0] frame_cnt_o
`endif
);

   localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam coord_t HLast     = coord_t'(HTotal - 1);
   localparam coord_t VLast     = coord_t'(VTotal - 1);
   localparam coord_t HAct      = coord_t'(H_ACTIVE);
   localparam coord_t VAct      = coord_t'(V_ACTIVE);
   localparam coord_t HSyncBeg  = coord_t'(H_ACTIVE + H_FP);
   localparam coord_t HSyncEnd  = coord_t'(H_ACTIVE + H_FP + H_SYNC);
   localparam coord_t VSyncBeg  = coord_t'(V_ACTIVE + V_FP);
   localparam coord_t VSyncEnd  = coord_t'(V_ACTIVE + V_FP + V_SYNC);

   if (CLK_DIV < 1) begin : g_bad_div
      $error("vga_timing_gen: CLK_DIV must be at least 1");
   end
   if (HTotal > 1023) begin : g_bad_htotal
      $error("vga_timing_gen: H_TOTAL exceeds 1023");
   end
   if (VTotal > 1023) begin : g_bad_vtotal
      $error("vga_timing_gen: V_TOTAL exceeds 1023");
   end

   logic   tick_d;
   coord_t hc_q, hc_d, vc_q, vc_d;
   logic   hsync_q, hsync_d, vsync_q, vsync_d, video_q, video_d;
   logic   line_q, line_d, frame_q, frame_d;

   vga_pix_divider #(
      .CLK_DIV (CLK_DIV)
   ) u_div (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .tick_next_o (tick_d),
      .pix_tick_o  (pix_tick_o)
   );

   // Counter advance on the upcoming tick, then decode syncs/blanking from the new counts.
   always_comb begin
      hc_d    = hc_q;
      vc_d    = vc_q;
      line_d  = 1'b0;
      frame_d = 1'b0;
      if (tick_d) begin
         if (hc_q == HLast) begin
            hc_d   = '0;
            line_d = 1'b1;
            if (vc_q == VLast) begin
               vc_d    = '0;
               frame_d = 1'b1;
            end else begin
               vc_d = vc_q + coord_t'(1);
            end
         end else begin
            hc_d = hc_q + coord_t'(1);
         end
      end
      hsync_d = !((hc_d >= HSyncBeg) && (hc_d < HSyncEnd));
      vsync_d = !((vc_d >= VSyncBeg) && (vc_d < VSyncEnd));
      video_d = (hc_d < HAct) && (vc_d < VAct);
   end

   // Counter and decoded-output registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hc_q    <= '0;
         vc_q    <= '0;
         hsync_q <= 1'b1;
         vsync_q <= 1'b1;
         video_q <= 1'b1;
         line_q  <= 1'b0;
         frame_q <= 1'b0;
      end else begin
         hc_q    <= hc_d;
         vc_q    <= vc_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
         video_q <= video_d;
         line_q  <= line_d;
         frame_q <= frame_d;
      end
   end

   assign hc_o          = hc_q;
   assign vc_o          = vc_q;
   assign hsync_o       = hsync_q;
   assign vsync_o       = vsync_q;
   assign video_on_o    = video_q;
   assign line_start_o  = line_q;
   assign frame_start_o = frame_q;

`ifdef VGA_FRAME_COUNT_EN
   logic [15:0] frame_cnt_q;

   // Frame counter bumps in the same clk frame_start goes high; wraps naturally.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         frame_cnt_q <= '0;
      end else if (frame_d) begin
         frame_cnt_q <= frame_cnt_q + 16'd1;
      end
   end

   assign frame_cnt_o = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen. Two instances with a reduced raster
// (32x17 total) so whole frames fit in a short run: one at CLK_DIV=3, one at
// CLK_DIV=1. Expected outputs come from clock counts since reset release.
module tb_vga_timing_gen;
   import vga_pkg::*;

   localparam int unsigned HA = 20, HF = 3, HS = 4, HB = 5;
   localparam int unsigned VA = 10, VF = 2, VS = 2, VB = 3;
   localparam int unsigned HT = HA + HF + HS + HB;
   localparam int unsigned VT = VA + VF + VS + VB;
   localparam int unsigned DIV_A = 3;
   localparam int unsigned DIV_B = 1;

   typedef struct packed {
      logic        tick;
      logic [9:0]  hc;
      logic [9:0]  vc;
      logic        hs;
      logic        vs;
      logic        vid;
      logic        ls;
      logic        fs;
      logic [15:0] fc;
   } obs_t;

   logic   clk;
   logic   rst_n;
   logic   tick_a, hs_a, vs_a, vid_a, ls_a, fs_a;
   logic   tick_b, hs_b, vs_b, vid_b, ls_b, fs_b;
   coord_t hc_a, vc_a, hc_b, vc_b;
   logic [15:0] fc_a, fc_b;

   obs_t        q_a[$];
   obs_t        q_b[$];
   int unsigned n;
   int unsigned cyc;
   int          checks;
   int          errors;
   bit          mon_en;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   vga_timing_gen #(
      .CLK_DIV (DIV_A), .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
      .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
   ) u_dut_a (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .pix_tick_o    (tick_a),
      .hc_o          (hc_a),
      .vc_o          (vc_a),
      .hsync_o       (hs_a),
      .vsync_o       (vs_a),
      .video_on_o    (vid_a),
      .line_start_o  (ls_a),
      .frame_start_o (fs_a)
`ifdef VGA_FRAME_COUNT_EN
      ,
      .frame_cnt_o   (fc_a)
`endif
   );

   vga_timing_gen #(
      .CLK_DIV (DIV_B), .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
      .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
   ) u_dut_b (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .pix_tick_o    (tick_b),
      .hc_o          (hc_b),
      .vc_o          (vc_b),
      .hsync_o       (hs_b),
      .vsync_o       (vs_b),
      .video_on_o    (vid_b),
      .line_start_o  (ls_b),
      .frame_start_o (fs_b)
`ifdef VGA_FRAME_COUNT_EN
      ,
      .frame_cnt_o   (fc_b)
`endif
   );

`ifndef VGA_FRAME_COUNT_EN
   assign fc_a = '0;
   assign fc_b = '0;
`endif

   // Reference: n clks since release -> n/div pixel ticks -> raster position.
   function automatic obs_t model(input int unsigned clks, input int unsigned div);
      obs_t        e;
      int unsigned t, h, v;
      t      = clks / div;
      h      = t % HT;
      v      = (t / HT) % VT;
      e.tick = (clks != 0) && (clks % div == 0);
      e.hc   = 10'(h);
      e.vc   = 10'(v);
      e.hs   = !((h >= HA + HF) && (h < HA + HF + HS));
      e.vs   = !((v >= VA + VF) && (v < VA + VF + VS));
      e.vid  = (h < HA) && (v < VA);
      e.ls   = e.tick && (h == 0);
      e.fs   = e.ls && (v == 0);
      e.fc   = 16'((t / (HT * VT)) % 65536);
      return e;
   endfunction

   function automatic logic [25:0] base(input obs_t o);
      return {o.tick, o.hc, o.vc, o.hs, o.vs, o.vid, o.ls, o.fs};
   endfunction

   task automatic compare(input string name, input obs_t act, input obs_t exp);
      checks++;
      if (base(act) != base(exp)) begin
         errors++;
         $display("FAIL %s cyc %0d: got tick=%b hc=%0d vc=%0d hs=%b vs=%b vid=%b ls=%b fs=%b, want tick=%b hc=%0d vc=%0d hs=%b vs=%b vid=%b ls=%b fs=%b",
                  name, cyc, act.tick, act.hc, act.vc, act.hs, act.vs, act.vid, act.ls, act.fs,
                  exp.tick, exp.hc, exp.vc, exp.hs, exp.vs, exp.vid, exp.ls, exp.fs);
      end
`ifdef VGA_FRAME_COUNT_EN
      checks++;
      if (act.fc != exp.fc) begin
         errors++;
         $display("FAIL %s frame_cnt cyc %0d: got %0d want %0d", name, cyc, act.fc, exp.fc);
      end
`endif
   endtask

   // Monitor: every falling edge, pop each scoreboard and compare with what the DUT shows.
   initial begin
      obs_t act, exp;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            act = '{tick: tick_a, hc: hc_a, vc: vc_a, hs: hs_a, vs: vs_a, vid: vid_a,
                    ls: ls_a, fs: fs_a, fc: fc_a};
            if (q_a.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL div3 scoreboard: got empty queue want entry at cyc %0d", cyc);
            end else begin
               exp = q_a.pop_front();
               compare("div3", act, exp);
            end
            act = '{tick: tick_b, hc: hc_b, vc: vc_b, hs: hs_b, vs: vs_b, vid: vid_b,
                    ls: ls_b, fs: fs_b, fc: fc_b};
            if (q_b.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL div1 scoreboard: got empty queue want entry at cyc %0d", cyc);
            end else begin
               exp = q_b.pop_front();
               compare("div1", act, exp);
            end
         end
      end
   end

   // One clk of stimulus: reset is changed 1ns after the edge, so an assertion
   // takes effect asynchronously mid-cycle and a release counts from the next edge.
   task automatic step(input logic rst_val);
      @(posedge clk);
      if (rst_n) n++;
      cyc++;
      #1;
      rst_n = rst_val;
      if (!rst_val) n = 0;
      q_a.push_back(model(n, DIV_A));
      q_b.push_back(model(n, DIV_B));
      mon_en = 1'b1;
   endtask

   initial begin
      int unsigned frame_clks;
      rst_n      = 1'b0;
      n          = 0;
      cyc        = 0;
      checks     = 0;
      errors     = 0;
      mon_en     = 1'b0;
      frame_clks = HT * VT * DIV_A;

      repeat (3) step(1'b0);
      // Three complete frames plus a margin from a clean release.
      repeat (3 * frame_clks + 40) step(1'b1);
      // Random mid-frame resets of random length followed by random run lengths.
      for (int i = 0; i < 8; i++) begin
         repeat ($urandom_range(1, 4)) step(1'b0);
         repeat ($urandom_range(1, 2 * frame_clks)) step(1'b1);
      end

      @(negedge clk);
      #1;
      if (q_a.size() != 0 || q_b.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d/%0d leftover entries want 0/0", q_a.size(), q_b.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
